mem_arbiter: RTL and testbench

Two-port arbiter that shares the single byte-wide program/data RAM between a host port (UART loader / debug) and the CPU port. It serialises byte reads and writes onto the RAM's separate read-address and write-address/strobe pins, and returns read data with a valid pulse to the requester that issued the read. It sits between the requesters and the RAM in the SoC top level, replacing direct CPU-to-RAM wiring.

---
 rtl/robin_pkg.sv | 13 +
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/robin_pkg.sv
// Shared constants for the RAM arbiter: FSM state encoding and port ids.
// Imported by mem_arbiter and mem_arb_pick.
package robin_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic [1:0] RDDONE = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between host (A) and CPU (B) requests.
// MEM_ARBITER_RR_EN selects round-robin; otherwise A has fixed priority.
module mem_arb_pick
  import robin_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic win
);

`ifdef MEM_ARBITER_RR_EN
  always_comb begin
    win = PORT_A;
    if (req_a && req_b) begin
      win = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      win = PORT_B;
    end
  end
`else
  // last is still tracked by the FSM but has no say here
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = PORT_A;
    if (!req_a && req_b) begin
      win = PORT_B;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port byte RAM arbiter (host A, CPU B) with registered RAM pins.
// Define MEM_ARBITER_RR_EN for round-robin instead of A-first priority.
module mem_arbiter
  import robin_pkg::*;
#(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [addr_width-1:0] addr_a,
  input  logic [7:0]            wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [addr_width-1:0] addr_b,
  input  logic [7:0]            wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic [7:0]            rdata_a,
  output logic [7:0]            rdata_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic                  busy,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  input  logic [7:0]            mem_data_out
);

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic                  win_q, win_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] raddr_q, raddr_d;
  logic [addr_width-1:0] waddr_q, waddr_d;
  logic [7:0]            wdat_q, wdat_d;
  logic                  mwr_q, mwr_d;
  logic [7:0]            rdata_a_q, rdata_a_d;
  logic [7:0]            rdata_b_q, rdata_b_d;

  logic                  pick;
  logic                  sel_we;
  logic [addr_width-1:0] sel_addr;
  logic [7:0]            sel_wdata;

  mem_arb_pick u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .last  (last_q),
    .win   (pick)
  );

  assign sel_we    = (pick == PORT_B) ? we_b    : we_a;
  assign sel_addr  = (pick == PORT_B) ? addr_b  : addr_a;
  assign sel_wdata = (pick == PORT_B) ? wdata_b : wdata_a;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    we_d      = we_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdat_d    = wdat_q;
    mwr_d     = 1'b0;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          win_d   = pick;
          we_d    = sel_we;
          state_d = ISSUE;
          if (sel_we) begin
            waddr_d = sel_addr;
            wdat_d  = sel_wdata;
            mwr_d   = 1'b1;
          end else begin
            raddr_d = sel_addr;
          end
        end
      end
      ISSUE: begin
        last_d  = win_q;
        state_d = we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // RAM output settles one cycle after mem_raddr was loaded
        if (win_q == PORT_B) begin
          rdata_b_d = mem_data_out;
        end else begin
          rdata_a_d = mem_data_out;
        end
        state_d = RDDONE;
      end
      RDDONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= PORT_B;
      win_q     <= PORT_A;
      we_q      <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdat_q    <= '0;
      mwr_q     <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      we_q      <= we_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wdat_q    <= wdat_d;
      mwr_q     <= mwr_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign gnt_a       = (state_q == ISSUE)  && (win_q == PORT_A);
  assign gnt_b       = (state_q == ISSUE)  && (win_q == PORT_B);
  assign rvalid_a    = (state_q == RDDONE) && (win_q == PORT_A);
  assign rvalid_b    = (state_q == RDDONE) && (win_q == PORT_B);
  assign busy        = (state_q != IDLE);
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;
  assign mem_raddr   = raddr_q;
  assign mem_waddr   = waddr_q;
  assign mem_data_in = wdat_q;
  assign mem_write   = mwr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a synchronous-read RAM model.
// Grant-order expectations follow MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [7:0]    wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [7:0]    rdata_a, rdata_b;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [7:0]    mem_data_in, mem_data_out;
  logic          mem_write;

  logic [7:0]    ram [0:(1<<AW)-1];

  int            n_chk = 0;
  int            n_fail = 0;
  logic [7:0]    rdq_a[$];
  logic [7:0]    rdq_b[$];

  mem_arbiter #(.addr_width(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_a        (req_a),
    .we_a         (we_a),
    .addr_a       (addr_a),
    .wdata_a      (wdata_a),
    .req_b        (req_b),
    .we_b         (we_b),
    .addr_b       (addr_b),
    .wdata_b      (wdata_b),
    .gnt_a        (gnt_a),
    .gnt_b        (gnt_b),
    .rdata_a      (rdata_a),
    .rdata_b      (rdata_b),
    .rvalid_a     (rvalid_a),
    .rvalid_b     (rvalid_b),
    .busy         (busy),
    .mem_raddr    (mem_raddr),
    .mem_waddr    (mem_waddr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_data_in;
    mem_data_out <= ram[mem_raddr];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid_a) begin
      if (rdq_a.size() == 0) chk("rvalid_a_unexp", 64'(1), 64'(0));
      else chk("rdata_a", 64'(rdata_a), 64'(rdq_a.pop_front()));
    end
    if (rvalid_b) begin
      if (rdq_b.size() == 0) chk("rvalid_b_unexp", 64'(1), 64'(0));
      else chk("rdata_b", 64'(rdata_b), 64'(rdq_b.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic port, input logic we,
                       input logic [AW-1:0] addr, input logic [7:0] wd);
    if (port) begin
      we_b = we; addr_b = addr; wdata_b = wd; req_b = 1'b1;
    end else begin
      we_a = we; addr_a = addr; wdata_a = wd; req_a = 1'b1;
    end
  endtask

  task automatic drop(input logic port);
    if (port) req_b = 1'b0;
    else req_a = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(busy), 64'(0));
  endtask

  task automatic xfer(input string tag, input logic port, input logic we,
                      input logic [AW-1:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp);
    int n = 0;
    logic g;
    drive(port, we, addr, wd);
    if (!we) begin
      if (port) rdq_b.push_back(exp);
      else rdq_a.push_back(exp);
    end
    do begin
      step();
      n++;
      g = port ? gnt_b : gnt_a;
    end while (!g && n < 20);
    chk({tag, "_gnt"}, 64'(g), 64'(1));
    drop(port);
    wait_idle({tag, "_idle"});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({gnt_a, gnt_b, rvalid_a, rvalid_b, busy,
                            mem_write}), 64'(0));
    chk({tag, "_raddr"}, 64'(mem_raddr), 64'(0));
    chk({tag, "_waddr"}, 64'(mem_waddr), 64'(0));
    chk({tag, "_wdat"}, 64'(mem_data_in), 64'(0));
    chk({tag, "_rdata"}, 64'({rdata_a, rdata_b}), 64'(0));
  endtask

  initial begin
    int order[$];
    int exp_ord[4];
    int exp_n;
    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (2) step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    // A write 0x010 = 0xA5, cycle-exact
    drive(1'b0, 1'b1, 9'h010, 8'hA5);
    step();
    chk("wr_gnt_a", 64'(gnt_a), 64'(1));
    chk("wr_gnt_b", 64'(gnt_b), 64'(0));
    chk("wr_mem_write", 64'(mem_write), 64'(1));
    chk("wr_waddr", 64'(mem_waddr), 64'(9'h010));
    chk("wr_wdata", 64'(mem_data_in), 64'(8'hA5));
    drop(1'b0);
    step();
    chk("wr_pulse", 64'({gnt_a, mem_write}), 64'(0));
    chk("wr_busy", 64'(busy), 64'(0));

    // B read-back of 0x010
    drive(1'b1, 1'b0, 9'h010, 8'h00);
    rdq_b.push_back(8'hA5);
    step();
    chk("rb_gnt_b", 64'(gnt_b), 64'(1));
    chk("rb_raddr", 64'(mem_raddr), 64'(9'h010));
    drop(1'b1);
    step();
    chk("rb_c2", 64'({gnt_b, rvalid_b}), 64'(0));
    step();
    chk("rb_rvalid_b", 64'(rvalid_b), 64'(1));
    chk("rb_a_quiet", 64'({rvalid_a, rdata_a}), 64'(0));
    step();
    chk("rb_c4", 64'({busy, rvalid_b}), 64'(0));

    // Boundary address 0x1FF
    xfer("bw", 1'b0, 1'b1, 9'h1FF, 8'h3C, 8'h00);
    drive(1'b0, 1'b0, 9'h1FF, 8'h00);
    rdq_a.push_back(8'h3C);
    step();
    chk("bd_gnt_a", 64'(gnt_a), 64'(1));
    chk("bd_raddr", 64'(mem_raddr), 64'(9'h1FF));
    drop(1'b0);
    repeat (2) step();
    chk("bd_rvalid_a", 64'(rvalid_a), 64'(1));
    step();
    chk("bd_hold", 64'(rdata_a), 64'(8'h3C));

    // B arrives during A's RDWAIT
    drive(1'b0, 1'b0, 9'h010, 8'h00);
    rdq_a.push_back(8'hA5);
    step();
    chk("bz_gnt_a", 64'(gnt_a), 64'(1));
    drop(1'b0);
    step();
    drive(1'b1, 1'b0, 9'h1FF, 8'h00);
    rdq_b.push_back(8'h3C);
    step();
    chk("bz_rvalid_a", 64'(rvalid_a), 64'(1));
    chk("bz_gnt_b_early3", 64'(gnt_b), 64'(0));
    step();
    chk("bz_gnt_b_early4", 64'(gnt_b), 64'(0));
    step();
    chk("bz_gnt_b", 64'(gnt_b), 64'(1));
    drop(1'b1);
    wait_idle("bz_idle");

    // Simultaneous held requests after reset
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    drive(1'b0, 1'b1, 9'h1FF, 8'h3C);
    drive(1'b1, 1'b0, 9'h010, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (gnt_a) order.push_back(0);
      if (gnt_b) begin
        order.push_back(1);
        rdq_b.push_back(8'hA5);
      end
    end
    drop(1'b0);
    drop(1'b1);
`ifdef MEM_ARBITER_RR_EN
    exp_ord = '{0, 1, 0, 1};
    exp_n = 4;
`else
    exp_ord = '{0, 0, 0, 0};
    exp_n = 5;
`endif
    chk("sim_ngnt", 64'(order.size()), 64'(exp_n));
    for (int i = 0; i < 4; i++) begin
      chk("sim_order", 64'(i < order.size() ? order[i] : 9),
          64'(exp_ord[i]));
    end
    wait_idle("sim_idle");

    // Reset in RDWAIT aborts the read
    drive(1'b0, 1'b0, 9'h010, 8'h00);
    step();
    chk("ra_gnt_a", 64'(gnt_a), 64'(1));
    drop(1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("rst_mid");
    for (int c = 0; c < 4; c++) begin
      step();
      chk("ra_no_rvalid", 64'(rvalid_a), 64'(0));
    end
    xfer("ra_new", 1'b1, 1'b0, 9'h1FF, 8'h00, 8'h3C);

    step();
    chk("rdq_a_left", 64'(rdq_a.size()), 64'(0));
    chk("rdq_b_left", 64'(rdq_b.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
